// File: rtl/vga_vram_arbiter_if.sv
// Host-side request/ack bus for the VGA framebuffer arbiter.
// master = host requester, slave = arbiter.
interface vga_vram_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
);
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;
    logic              host_rvalid;

    modport master (
        output host_req, host_we, host_addr, host_wdata,
        input  host_ack, host_rdata, host_rvalid
    );

    modport slave (
        input  host_req, host_we, host_addr, host_wdata,
        output host_ack, host_rdata, host_rvalid
    );
endinterface

// File: rtl/vga_vram_arbiter.sv
// vga_vram_arbiter: shares one single-port synchronous framebuffer RAM between
// VGA scanout (one fetch per 25 MHz pixel period) and a host req/ack port.
// Scanout data and syncs leave two system clocks after the counters arrive.
// Optional feature macro: VGA_TEST_PATTERN_EN adds a test_mode input that
// replaces RAM scanout with a generated pattern and frees every slot for the host.
module vga_vram_arbiter #(
    parameter int H_PIX   = 160,
    parameter int V_PIX   = 120,
    parameter int H_SHIFT = 2,
    parameter int V_SHIFT = 2,
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 8
) (
    input  logic              clk_50MHz,
    input  logic              clear,
    input  logic              clk_25MHz,
    input  logic [9:0]        h_count,
    input  logic [9:0]        v_count,
    input  logic              bright,
    input  logic              h_sync,
    input  logic              v_sync,
`ifdef VGA_TEST_PATTERN_EN
    input  logic              test_mode,
`endif
    output logic [DATA_W-1:0] pixel_out,
    output logic              h_sync_out,
    output logic              v_sync_out,
    output logic              bright_out,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    vga_vram_arbiter_if.slave host
);
    localparam int unsigned FB_SIZE = H_PIX * V_PIX;

    typedef enum logic [0:0] {H_IDLE, H_RWAIT} host_state_t;

    host_state_t       state_reg, state_next;
    logic              c25_q;
    logic              phase0;
    logic              test_active;
    logic              disp_slot;
    logic              grant;
    logic              in_range;
    logic [ADDR_W-1:0] disp_addr;
    logic              p1_reg;
    logic              stage_hs_reg, stage_vs_reg, stage_bright_reg;
    logic              rd_oor_reg;
    logic [DATA_W-1:0] host_rdata_reg;
    logic              host_rvalid_reg;
    logic [DATA_W-1:0] pix_src;

`ifdef VGA_TEST_PATTERN_EN
    logic [DATA_W-1:0] pattern;
    logic [DATA_W-1:0] stage_pat_reg;
    logic              stage_test_reg;

    assign test_active = test_mode;

    // Pattern bit gi is h_count[7] xor the counter bit aligned from bit 9 downward;
    // bits that fall below h_count[0] keep only the h_count[7] term.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_pattern
            localparam int SRC = 10 - DATA_W + gi;
            if (SRC >= 0) begin : g_xor
                assign pattern[gi] = h_count[7] ^ h_count[SRC];
            end else begin : g_pad
                assign pattern[gi] = h_count[7];
            end
        end
    endgenerate

    assign pix_src = stage_test_reg ? stage_pat_reg : ram_rdata;
`else
    assign test_active = 1'b0;
    assign pix_src     = ram_rdata;
`endif

    // Phase0 is the first system cycle after a pixel-clock rise; the display owns it when bright.
    assign phase0    = clk_25MHz & ~c25_q;
    assign disp_slot = phase0 & bright & ~test_active & ~clear;
    assign disp_addr = ADDR_W'(32'(v_count >> V_SHIFT) * 32'(H_PIX) + 32'(h_count >> H_SHIFT));
    assign in_range  = 32'(host.host_addr) < FB_SIZE;
    assign grant     = host.host_req & ~disp_slot & (state_reg == H_IDLE) & ~clear;

    assign host.host_ack    = grant;
    assign host.host_rdata  = host_rdata_reg;
    assign host.host_rvalid = host_rvalid_reg;

    // Host FSM next state and the RAM port mux (display first, then host, else idle).
    always_comb begin
        state_next = state_reg;
        ram_addr   = '0;
        ram_we     = 1'b0;
        ram_wdata  = '0;
        case (state_reg)
            H_IDLE:  if (grant && !host.host_we) state_next = H_RWAIT;
            H_RWAIT: state_next = H_IDLE;
            default: state_next = H_IDLE;
        endcase
        if (disp_slot) begin
            ram_addr = disp_addr;
        end else if (grant) begin
            ram_addr  = host.host_addr;
            ram_we    = host.host_we & in_range;
            ram_wdata = host.host_wdata;
        end
    end

    // Host FSM state, out-of-range read flag and registered read return.
    always_ff @(posedge clk_50MHz) begin
        if (clear) begin
            state_reg       <= H_IDLE;
            rd_oor_reg      <= 1'b0;
            host_rdata_reg  <= '0;
            host_rvalid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            host_rvalid_reg <= (state_reg == H_RWAIT);
            if (grant && !host.host_we)
                rd_oor_reg <= ~in_range;
            if (state_reg == H_RWAIT)
                host_rdata_reg <= rd_oor_reg ? '0 : ram_rdata;
        end
    end

    // Pixel-clock edge detect and the two-stage scanout pipeline (stage at phase0, output one cycle later).
    always_ff @(posedge clk_50MHz) begin
        if (clear) begin
            c25_q            <= 1'b1;
            p1_reg           <= 1'b0;
            stage_hs_reg     <= 1'b0;
            stage_vs_reg     <= 1'b0;
            stage_bright_reg <= 1'b0;
            pixel_out        <= '0;
            h_sync_out       <= 1'b0;
            v_sync_out       <= 1'b0;
            bright_out       <= 1'b0;
        end else begin
            c25_q  <= clk_25MHz;
            p1_reg <= phase0;
            if (phase0) begin
                stage_hs_reg     <= h_sync;
                stage_vs_reg     <= v_sync;
                stage_bright_reg <= bright;
            end
            if (p1_reg) begin
                pixel_out  <= stage_bright_reg ? pix_src : '0;
                h_sync_out <= stage_hs_reg;
                v_sync_out <= stage_vs_reg;
                bright_out <= stage_bright_reg;
            end
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    // Pattern value and mode travel with the syncs so test output keeps the same latency.
    always_ff @(posedge clk_50MHz) begin
        if (clear) begin
            stage_pat_reg  <= '0;
            stage_test_reg <= 1'b0;
        end else if (phase0) begin
            stage_pat_reg  <= pattern;
            stage_test_reg <= test_mode;
        end
    end
`endif
endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed bench for vga_vram_arbiter: table of scanout vectors plus hand-written
// host read/write, reset and sync-latency sequences against a behavioural RAM.
module tb_vga_vram_arbiter;
    logic       clk = 1'b0;
    logic       clear;
    logic       clk_25MHz;
    logic [9:0] h_count, v_count;
    logic       bright, h_sync, v_sync;
`ifdef VGA_TEST_PATTERN_EN
    logic       test_mode = 1'b0;
`endif
    logic [7:0]  pixel_out;
    logic        h_sync_out, v_sync_out, bright_out;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        tb_phase0;
    logic        c25_prev;

    int checks = 0;
    int errors = 0;

    vga_vram_arbiter_if #(.ADDR_W(15), .DATA_W(8)) hif();

    vga_vram_arbiter dut (
        .clk_50MHz (clk),
        .clear     (clear),
        .clk_25MHz (clk_25MHz),
        .h_count   (h_count),
        .v_count   (v_count),
        .bright    (bright),
        .h_sync    (h_sync),
        .v_sync    (v_sync),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode (test_mode),
`endif
        .pixel_out (pixel_out),
        .h_sync_out(h_sync_out),
        .v_sync_out(v_sync_out),
        .bright_out(bright_out),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .host      (hif)
    );

    always #10 clk = ~clk;

    // Behavioural RAM: unwritten words read as addr[7:0], except 19200 which reads 0x77.
    bit [7:0] mem [0:32767];
    bit       written [0:32767];
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr]     <= ram_wdata;
            written[ram_addr] <= 1'b1;
        end
        if (written[ram_addr])
            ram_rdata <= mem[ram_addr];
        else if (ram_addr == 15'd19200)
            ram_rdata <= 8'h77;
        else
            ram_rdata <= ram_addr[7:0];
    end

    // Pixel clock: toggles every system cycle just after the rising edge.
    initial begin
        clk_25MHz = 1'b0;
        c25_prev  = 1'b0;
        tb_phase0 = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            c25_prev  = clk_25MHz;
            clk_25MHz = ~clk_25MHz;
            tb_phase0 = clk_25MHz && !c25_prev;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_phase0();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (tb_phase0) return;
        end
        chk("wait_phase0", 32'(tb_phase0), 32'd1);
    endtask

    task automatic host_drive(input logic req, input logic we, input logic [14:0] addr, input logic [7:0] wd);
        hif.host_req   = req;
        hif.host_we    = we;
        hif.host_addr  = addr;
        hif.host_wdata = wd;
    endtask

    typedef struct {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        b;
        logic        hs;
        logic        vs;
        logic [14:0] exp_addr;
        logic [7:0]  exp_pix;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{10'd8,   10'd4,   1'b1, 1'b1, 1'b1, 15'd162,   8'hA2};
        vecs[1] = '{10'd4,   10'd0,   1'b1, 1'b0, 1'b1, 15'd1,     8'h01};
        vecs[2] = '{10'd639, 10'd479, 1'b1, 1'b1, 1'b0, 15'd19199, 8'hFF};
        vecs[3] = '{10'd100, 10'd200, 1'b1, 1'b0, 1'b0, 15'd8025,  8'h59};
        vecs[4] = '{10'd300, 10'd10,  1'b0, 1'b1, 1'b0, 15'd0,     8'h00};
        vecs[5] = '{10'd700, 10'd500, 1'b0, 1'b0, 1'b0, 15'd0,     8'h00};
        vecs[6] = '{10'd20,  10'd8,   1'b1, 1'b1, 1'b1, 15'd325,   8'h45};

        // Reset held over two edges mid-frame with a pending host write.
        clear = 1'b1;
        h_count = 10'd8; v_count = 10'd4; bright = 1'b1; h_sync = 1'b1; v_sync = 1'b1;
        host_drive(1'b1, 1'b1, 15'd5, 8'h33);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_ack", 32'(hif.host_ack), 32'd0);
            chk("rst_we", 32'(ram_we), 32'd0);
            chk("rst_pix", 32'(pixel_out), 32'd0);
            chk("rst_syncs", 32'({h_sync_out, v_sync_out, bright_out}), 32'd0);
            chk("rst_rvalid", 32'({hif.host_rvalid, hif.host_rdata}), 32'd0);
            $display("reset cycle %0d: ack=%0b pixel=%0h", i, hif.host_ack, pixel_out);
        end
        clear = 1'b0;
        host_drive(1'b0, 1'b0, 15'd0, 8'h00);
        #1;
        chk("post_rst_addr", 32'(ram_addr), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("resume_addr", 32'(ram_addr), tb_phase0 ? 32'd162 : 32'd0);
            $display("resume cycle %0d: phase0=%0b ram_addr=%0d", i, tb_phase0, ram_addr);
        end

        // Table-driven scanout: apply in phase0, check address now and outputs two clocks later.
        wait_phase0();
        for (int i = 0; i < 7; i++) begin
            if (i > 0) begin
                chk("vec_pix", 32'(pixel_out), 32'(vecs[i-1].exp_pix));
                chk("vec_hs", 32'(h_sync_out), 32'(vecs[i-1].hs));
                chk("vec_vs", 32'(v_sync_out), 32'(vecs[i-1].vs));
                chk("vec_bright", 32'(bright_out), 32'(vecs[i-1].b));
            end
            h_count = vecs[i].h; v_count = vecs[i].v; bright = vecs[i].b;
            h_sync = vecs[i].hs; v_sync = vecs[i].vs;
            #1;
            chk("vec_addr", 32'(ram_addr), 32'(vecs[i].exp_addr));
            chk("vec_we", 32'(ram_we), 32'd0);
            $display("vec %0d: h=%0d v=%0d bright=%0b ram_addr=%0d", i, h_count, v_count, bright, ram_addr);
            @(negedge clk);
            @(negedge clk);
        end
        chk("vec_pix", 32'(pixel_out), 32'(vecs[6].exp_pix));
        chk("vec_hs", 32'(h_sync_out), 32'(vecs[6].hs));

        // Host write during bright: deferred to phase1, display read undisturbed.
        h_count = 10'd8; v_count = 10'd4; bright = 1'b1; h_sync = 1'b0; v_sync = 1'b0;
        host_drive(1'b1, 1'b1, 15'd5, 8'hA5);
        #1;
        chk("wr_ack_phase0", 32'(hif.host_ack), 32'd0);
        chk("wr_addr_phase0", 32'(ram_addr), 32'd162);
        @(negedge clk);
        chk("wr_ack_phase1", 32'(hif.host_ack), 32'd1);
        chk("wr_bus", 32'({ram_we, ram_addr, ram_wdata}), 32'({1'b1, 15'd5, 8'hA5}));
        @(posedge clk); #1;
        host_drive(1'b0, 1'b0, 15'd0, 8'h00);
        @(negedge clk);
        chk("wr_disp_pix", 32'(pixel_out), 32'hA2);
        chk("wr_mem5", 32'(mem[5]), 32'hA5);
        $display("host write addr 5 data a5: mem[5]=%0h pixel=%0h", mem[5], pixel_out);

        // Host reads in blanking; a second read is held off while the first is in flight.
        bright = 1'b0;
        host_drive(1'b1, 1'b0, 15'd5, 8'h00);
        #1;
        chk("rd_ack", 32'(hif.host_ack), 32'd1);
        chk("rd_bus", 32'({ram_we, ram_addr}), 32'({1'b0, 15'd5}));
        @(posedge clk); #1;
        host_drive(1'b1, 1'b0, 15'd162, 8'h00);
        @(negedge clk);
        chk("rd_rwait_ack", 32'(hif.host_ack), 32'd0);
        chk("rd_rvalid_early", 32'(hif.host_rvalid), 32'd0);
        @(negedge clk);
        chk("rd_rvalid", 32'(hif.host_rvalid), 32'd1);
        chk("rd_rdata", 32'(hif.host_rdata), 32'hA5);
        chk("rd2_ack", 32'(hif.host_ack), 32'd1);
        $display("host read addr 5: rdata=%0h", hif.host_rdata);
        @(posedge clk); #1;
        host_drive(1'b0, 1'b0, 15'd0, 8'h00);
        @(negedge clk);
        chk("rd2_rvalid_early", 32'(hif.host_rvalid), 32'd0);
        @(negedge clk);
        chk("rd2_rvalid", 32'(hif.host_rvalid), 32'd1);
        chk("rd2_rdata", 32'(hif.host_rdata), 32'hA2);
        $display("host read addr 162: rdata=%0h", hif.host_rdata);
        @(negedge clk);
        chk("rd2_rvalid_pulse", 32'(hif.host_rvalid), 32'd0);

        // Out-of-range write then back-to-back read.
        host_drive(1'b1, 1'b1, 15'd19200, 8'h5A);
        #1;
        chk("oor_wr_ack", 32'(hif.host_ack), 32'd1);
        chk("oor_wr_we", 32'(ram_we), 32'd0);
        @(posedge clk); #1;
        host_drive(1'b1, 1'b0, 15'd19200, 8'h00);
        @(negedge clk);
        chk("oor_rd_ack", 32'(hif.host_ack), 32'd1);
        @(posedge clk); #1;
        host_drive(1'b0, 1'b0, 15'd0, 8'h00);
        @(negedge clk);
        chk("oor_rvalid_early", 32'(hif.host_rvalid), 32'd0);
        @(negedge clk);
        chk("oor_rvalid", 32'(hif.host_rvalid), 32'd1);
        chk("oor_rdata", 32'(hif.host_rdata), 32'd0);
        chk("oor_not_written", 32'(written[19200]), 32'd0);
        $display("host oor addr 19200: rdata=%0h", hif.host_rdata);

        // Sync latency: h_sync rising in phase0 appears two clocks later.
        wait_phase0();
        h_sync = 1'b0; v_sync = 1'b0; bright = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        chk("hs_before", 32'(h_sync_out), 32'd0);
        h_sync = 1'b1;
        @(negedge clk);
        chk("hs_t1", 32'(h_sync_out), 32'd0);
        @(negedge clk);
        chk("hs_t2", 32'(h_sync_out), 32'd1);
        chk("hs_blank_pix", 32'(pixel_out), 32'd0);
        chk("hs_blank_bright", 32'(bright_out), 32'd0);
        $display("hsync toggle: h_sync_out=%0b pixel=%0h", h_sync_out, pixel_out);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
